// File: rtl/s2p_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel stage.
package s2p_pkg;

  typedef enum logic {HUNT, SHIFT} asm_state_t;

  // Width of an occupancy counter able to hold 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: head word visible whenever not empty, zero latency.
// Push is accepted when not full or when a pop happens on the same edge; pop on empty is ignored.
module sync_fifo
  import s2p_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            pop_data,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        full,
  output logic                        empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  // Pointers carry a wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign rd_ok = pop & ~empty;
  assign wr_ok = push & (~full | rd_ok);

  // Gated so the head reads zero while nothing is buffered.
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/serial_to_parallel.sv
// Reassembles a qualified serial stream into words and buffers them; word visible one edge after its last bit.
// Output drains on dout_valid & dout_ready; a word completing into a full FIFO with no pop is dropped and flagged.
module serial_to_parallel
  import s2p_pkg::*;
#(
  parameter int DATA_WIDTH    = 4,
  parameter int MSB_FIRST     = 1,
  parameter int FIFO_DEPTH    = 4,
  parameter int REQUIRE_FRAME = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             din,
  input  logic                             din_en,
  input  logic                             frame,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic                             dout_valid,
  input  logic                             dout_ready,
  output logic                             overflow,
  input  logic                             ovf_clr,
  output logic [cnt_width(FIFO_DEPTH)-1:0] fifo_count
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);
  localparam asm_state_t RST_STATE = (REQUIRE_FRAME != 0) ? HUNT : SHIFT;

  asm_state_t            state, state_nxt;
  logic [BW-1:0]         cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] sr, sr_nxt;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] first_sr;
  logic                  push;
  logic                  full;
  logic                  empty;
  logic                  drop;

  // The shift direction decides where the first bit ends up once the word is complete.
  assign shifted  = (MSB_FIRST != 0) ? {sr[DATA_WIDTH-2:0], din} : {din, sr[DATA_WIDTH-1:1]};
  assign first_sr = (MSB_FIRST != 0) ? {{(DATA_WIDTH-1){1'b0}}, din}
                                     : {din, {(DATA_WIDTH-1){1'b0}}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RST_STATE;
      cnt   <= '0;
      sr    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sr    <= sr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sr_nxt    = sr;
    push      = 1'b0;
    if (din_en) begin
      if (frame) begin
        // A marker restarts the word; any partial bits are abandoned.
        state_nxt = SHIFT;
        sr_nxt    = first_sr;
        cnt_nxt   = BW'(1);
      end else if (state == SHIFT) begin
        if (cnt == LAST) begin
          push    = 1'b1;
          sr_nxt  = '0;
          cnt_nxt = '0;
        end else begin
          sr_nxt  = shifted;
          cnt_nxt = cnt + 1'b1;
        end
      end
    end
  end

  // Full implies non-empty, so dout_ready alone tells whether a pop frees a slot.
  assign drop = push & full & ~dout_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (shifted),
    .pop       (dout_ready),
    .pop_data  (dout),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

  assign dout_valid = ~empty;

endmodule
